// File: rtl/udma_filter_pkg.sv
// ============================================================================
// Module : udma_filter_pkg
// Brief  : Shared mode/state encodings and step helper for the TX data fetch.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package udma_filter_pkg;

    typedef enum logic [1:0] {
        MODE_LINEAR   = 2'd0,
        MODE_SLIDING  = 2'd1,
        MODE_CIRCULAR = 2'd2,
        MODE_2D       = 2'd3
    } mode_e;

    localparam logic [1:0] DS_8  = 2'b00;
    localparam logic [1:0] DS_16 = 2'b01;
    localparam logic [1:0] DS_32 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Reserved size encoding 11 deliberately yields a zero step.
    function automatic logic [2:0] step_inc(input logic [1:0] ds);
        logic [2:0] inc;
        case (ds)
            DS_8:    inc = 3'd1;
            DS_16:   inc = 3'd2;
            DS_32:   inc = 3'd4;
            default: inc = 3'd0;
        endcase
        return inc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/udma_filter_sync_fifo.sv
// ============================================================================
// Module : udma_filter_sync_fifo
// Brief  : Synchronous-reset word FIFO with occupancy count and full/empty.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module udma_filter_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CW-1:0]         elements_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        // A push into a full FIFO is only legal when the head leaves this cycle.
        do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign data_o     = mem_q[rd_ptr_q];
    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign elements_o = count_q;

endmodule

`default_nettype wire

// File: rtl/udma_filter_tx_datafetch.sv
// ============================================================================
// Module : udma_filter_tx_datafetch
// Brief  : L2 read engine: address generation, credit-limited reads, FIFO out.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module udma_filter_tx_datafetch
    import udma_filter_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int L2_AWIDTH_NOAL = 15,
    parameter int BUFFER_DEPTH   = 4,
    parameter int TRANS_SIZE     = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    output logic                      tx_ch_req_o,
    output logic [L2_AWIDTH_NOAL-1:0] tx_ch_addr_o,
    output logic [1:0]                tx_ch_datasize_o,
    input  logic                      tx_ch_gnt_i,
    input  logic                      tx_ch_valid_i,
    input  logic [DATA_WIDTH-1:0]     tx_ch_data_i,
    input  logic                      cmd_start_i,
    output logic                      cmd_done_o,
    input  logic [L2_AWIDTH_NOAL-1:0] cfg_start_addr_i,
    input  logic [1:0]                cfg_datasize_i,
    input  logic [1:0]                cfg_mode_i,
    input  logic [TRANS_SIZE-1:0]     cfg_len0_i,
    input  logic [TRANS_SIZE-1:0]     cfg_len1_i,
    input  logic [TRANS_SIZE-1:0]     cfg_len2_i,
    output logic [DATA_WIDTH-1:0]     stream_data_o,
    output logic                      stream_valid_o,
    input  logic                      stream_ready_i
);

    localparam int CW = $clog2(BUFFER_DEPTH + 1);
    localparam int SW = CW + 1;
    localparam int AW = L2_AWIDTH_NOAL;

    state_e                state_q, state_d;
    mode_e                 mode_q, mode_d;
    logic [AW-1:0]         ptr_q, ptr_d;
    logic [AW-1:0]         row_base_q, row_base_d;
    logic [TRANS_SIZE-1:0] w_q, w_d;
    logic [TRANS_SIZE-1:0] l_q, l_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;
    logic                  req_q, req_d;
    logic                  done_q, done_d;

    logic [CW-1:0]         fifo_elements;
    logic                  fifo_empty;
    logic                  fifo_full_unused;
    logic                  grant;
    logic                  pop;
    logic [AW-1:0]         inc;
    logic [AW-1:0]         len2_ext;
    logic [SW-1:0]         fifo_cnt_next;
    logic [SW-1:0]         credit_sum;

    assign inc      = AW'(step_inc(cfg_datasize_i));
    assign len2_ext = AW'(cfg_len2_i);
    assign grant    = req_q && tx_ch_gnt_i;
    assign pop      = !fifo_empty && stream_ready_i;

    always_comb begin
        outstanding_d = outstanding_q;
        if (grant && !tx_ch_valid_i) begin
            outstanding_d = outstanding_q + CW'(1);
        end else if (!grant && tx_ch_valid_i) begin
            outstanding_d = outstanding_q - CW'(1);
        end
        fifo_cnt_next = SW'(fifo_elements) + SW'(tx_ch_valid_i) - SW'(pop);
        credit_sum    = SW'(outstanding_d) + fifo_cnt_next;

        state_d    = state_q;
        mode_d     = mode_q;
        ptr_d      = ptr_q;
        row_base_d = row_base_q;
        w_d        = w_q;
        l_d        = l_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_start_i) begin
                    mode_d     = mode_e'(cfg_mode_i);
                    ptr_d      = cfg_start_addr_i;
                    row_base_d = cfg_start_addr_i;
                    w_d        = '0;
                    l_d        = '0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (grant) begin
                    if (w_q < cfg_len0_i) begin
                        w_d   = w_q + TRANS_SIZE'(1);
                        ptr_d = ptr_q + inc;
                    end else if (mode_q == MODE_LINEAR || l_q == cfg_len1_i) begin
                        state_d = ST_DRAIN;
                    end else begin
                        w_d = '0;
                        l_d = l_q + TRANS_SIZE'(1);
                        case (mode_q)
                            MODE_SLIDING: begin
                                row_base_d = row_base_q + inc;
                                ptr_d      = row_base_q + inc;
                            end
                            MODE_CIRCULAR: begin
                                ptr_d = row_base_q;
                            end
                            default: begin
                                row_base_d = row_base_q + len2_ext;
                                ptr_d      = row_base_q + len2_ext;
                            end
                        endcase
                    end
                end
            end
            ST_DRAIN: begin
                if (outstanding_d == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Sum of in-flight and buffered words never grows without a grant,
        // so a raised request stays raised until it is accepted.
        req_d = (state_d == ST_RUN) && (credit_sum < SW'(BUFFER_DEPTH));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            mode_q        <= MODE_LINEAR;
            ptr_q         <= '0;
            row_base_q    <= '0;
            w_q           <= '0;
            l_q           <= '0;
            outstanding_q <= '0;
            req_q         <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            ptr_q         <= ptr_d;
            row_base_q    <= row_base_d;
            w_q           <= w_d;
            l_q           <= l_d;
            outstanding_q <= outstanding_d;
            req_q         <= req_d;
            done_q        <= done_d;
        end
    end

    udma_filter_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUFFER_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (tx_ch_valid_i),
        .data_i     (tx_ch_data_i),
        .pop_i      (pop),
        .data_o     (stream_data_o),
        .full_o     (fifo_full_unused),
        .empty_o    (fifo_empty),
        .elements_o (fifo_elements)
    );

    assign tx_ch_req_o      = req_q;
    assign tx_ch_addr_o     = ptr_q;
    assign tx_ch_datasize_o = cfg_datasize_i;
    assign cmd_done_o       = done_q;
    assign stream_valid_o   = !fifo_empty;

endmodule

`default_nettype wire
